// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
//   Sizes: entry index width, depth, result width, register/predicate address widths.
//   Instruction type encodings and helpers that turn a type into a register-file or predicate write.
package reorder_buffer_pkg;

    localparam int ROB_ID_SIZE    = 4;
    localparam int ROB_DEPTH      = 16;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_SIZE  = 5;
    localparam int PRED_ADDR_SIZE = 3;
    localparam int INS_TYPE_SIZE  = 2;
    localparam int INS_STATE_SIZE = 1;

    // bit 1: writes a destination, bit 0: predicate (1) or GPR (0) destination
    typedef enum logic [INS_TYPE_SIZE-1:0] {
        INS_TYPE_NONE = 2'b00,
        INS_TYPE_REG  = 2'b10,
        INS_TYPE_PRED = 2'b11
    } ins_type_e;

    localparam logic [INS_STATE_SIZE-1:0] INS_STATE_DONE = 1'b1;

    function automatic logic writes_reg(input logic [INS_TYPE_SIZE-1:0] ins_type);
        return ins_type == INS_TYPE_REG;
    endfunction

    function automatic logic writes_pred(input logic [INS_TYPE_SIZE-1:0] ins_type);
        return ins_type == INS_TYPE_PRED;
    endfunction

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// Entry storage for the reorder buffer.
//   clk, reset          : clock, synchronous active-high reset (clears all valid bits)
//   alloc_*             : allocate write port, writes a whole entry at alloc_idx
//   cmpl_*              : completion write port, marks an already-valid entry done and stores its result
//   retire_en/idx       : clears the valid bit of the retiring entry
//   head_idx, head_*    : combinational read of the entry at head_idx
module reorder_buffer_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int ID_W    = ROB_ID_SIZE,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int ADDR_W  = REG_ADDR_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_en,
    input  logic [ID_W-1:0]          alloc_idx,
    input  logic [INS_TYPE_SIZE-1:0] alloc_type,
    input  logic [ADDR_W-1:0]        alloc_dest,
    input  logic                     alloc_done,
    input  logic                     cmpl_en,
    input  logic [ID_W-1:0]          cmpl_idx,
    input  logic [DATA_W-1:0]        cmpl_data,
    input  logic                     retire_en,
    input  logic [ID_W-1:0]          retire_idx,
    input  logic [ID_W-1:0]          head_idx,
    output logic                     head_valid,
    output logic                     head_done,
    output logic [INS_TYPE_SIZE-1:0] head_type,
    output logic [ADDR_W-1:0]        head_dest,
    output logic [DATA_W-1:0]        head_data
);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         done_q;
    logic [INS_TYPE_SIZE-1:0] type_q [DEPTH];
    logic [ADDR_W-1:0]        dest_q [DEPTH];
    logic [DATA_W-1:0]        data_q [DEPTH];

    // Completion is gated by the registered valid bit, so a completion aimed at
    // the slot being allocated this cycle is dropped. Allocation and retire never
    // target the same slot: tail==head only when empty (no retire) or full (no allocate).
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (retire_en) begin
                valid_q[retire_idx] <= 1'b0;
            end
            if (alloc_en) begin
                valid_q[alloc_idx] <= 1'b1;
                done_q[alloc_idx]  <= alloc_done;
                type_q[alloc_idx]  <= alloc_type;
                dest_q[alloc_idx]  <= alloc_dest;
                data_q[alloc_idx]  <= '0;
            end
            if (cmpl_en && valid_q[cmpl_idx]) begin
                done_q[cmpl_idx] <= 1'b1;
                data_q[cmpl_idx] <= cmpl_data;
            end
        end
    end

    assign head_valid = valid_q[head_idx];
    assign head_done  = done_q[head_idx];
    assign head_type  = type_q[head_idx];
    assign head_dest  = dest_q[head_idx];
    assign head_data  = data_q[head_idx];

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Allocates one entry per request from decode,
// marks entries done on completion from execute, and retires at most one
// entry per cycle in program order through registered GPR/predicate write ports.
// ROB_DEPTH must equal 2**ROB_ID_SIZE so the pointers wrap naturally.
//   clk, reset                         : clock, synchronous active-high reset
//   add_rob_entry, entry_*             : allocation request and entry contents
//   entry_id, rob_full, rob_empty      : next id to allocate and occupancy flags (register-decoded)
//   complete_en/id/data                : completion from execute
//   wr_reg_*, wr_pred_*                : registered retirement writes
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH_P      = ROB_DEPTH,
    parameter int ROB_ID_SIZE_P    = ROB_ID_SIZE,
    parameter int DATA_WIDTH_P     = DATA_WIDTH,
    parameter int REG_ADDR_SIZE_P  = REG_ADDR_SIZE,
    parameter int PRED_ADDR_SIZE_P = PRED_ADDR_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        add_rob_entry,
    input  logic [INS_TYPE_SIZE-1:0]    entry_ins_type,
    input  logic [REG_ADDR_SIZE_P-1:0]  entry_dest_addr,
    input  logic [INS_STATE_SIZE-1:0]   entry_ins_state,
    output logic [ROB_ID_SIZE_P-1:0]    entry_id,
    output logic                        rob_full,
    output logic                        rob_empty,
    input  logic                        complete_en,
    input  logic [ROB_ID_SIZE_P-1:0]    complete_id,
    input  logic [DATA_WIDTH_P-1:0]     complete_data,
    output logic                        wr_reg_en,
    output logic [REG_ADDR_SIZE_P-1:0]  wr_reg_addr,
    output logic [DATA_WIDTH_P-1:0]     wr_reg_data,
    output logic                        wr_pred_en,
    output logic [PRED_ADDR_SIZE_P-1:0] wr_pred_addr,
    output logic                        wr_pred_data
);

    localparam int CNT_W = ROB_ID_SIZE_P + 1;

    logic [ROB_ID_SIZE_P-1:0]   head_q;
    logic [ROB_ID_SIZE_P-1:0]   tail_q;
    logic [CNT_W-1:0]           count_q;

    logic                       alloc_en;
    logic                       retire_en;
    logic                       head_valid;
    logic                       head_done;
    logic [INS_TYPE_SIZE-1:0]   head_type;
    logic [REG_ADDR_SIZE_P-1:0] head_dest;
    logic [DATA_WIDTH_P-1:0]    head_data;

    assign entry_id  = tail_q;
    assign rob_full  = (count_q == CNT_W'(ROB_DEPTH_P));
    assign rob_empty = (count_q == '0);

    // rob_full comes from the registered count, so a slot freed by this cycle's
    // retire is not offered to decode until the next cycle.
    assign alloc_en  = add_rob_entry & ~rob_full;
    assign retire_en = head_valid & head_done;

    reorder_buffer_entry_array #(
        .DEPTH  (ROB_DEPTH_P),
        .ID_W   (ROB_ID_SIZE_P),
        .DATA_W (DATA_WIDTH_P),
        .ADDR_W (REG_ADDR_SIZE_P)
    ) u_entry_array (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_idx  (tail_q),
        .alloc_type (entry_ins_type),
        .alloc_dest (entry_dest_addr),
        .alloc_done (entry_ins_state == INS_STATE_DONE),
        .cmpl_en    (complete_en),
        .cmpl_idx   (complete_id),
        .cmpl_data  (complete_data),
        .retire_en  (retire_en),
        .retire_idx (head_q),
        .head_idx   (head_q),
        .head_valid (head_valid),
        .head_done  (head_done),
        .head_type  (head_type),
        .head_dest  (head_dest),
        .head_data  (head_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            wr_reg_en    <= 1'b0;
            wr_reg_addr  <= '0;
            wr_reg_data  <= '0;
            wr_pred_en   <= 1'b0;
            wr_pred_addr <= '0;
            wr_pred_data <= 1'b0;
        end else begin
            if (alloc_en) begin
                tail_q <= tail_q + ROB_ID_SIZE_P'(1);
            end
            if (retire_en) begin
                head_q <= head_q + ROB_ID_SIZE_P'(1);
            end
            case ({alloc_en, retire_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            wr_reg_en  <= retire_en & writes_reg(head_type);
            wr_pred_en <= retire_en & writes_pred(head_type);
            if (retire_en) begin
                wr_reg_addr  <= head_dest;
                wr_reg_data  <= head_data;
                wr_pred_addr <= head_dest[PRED_ADDR_SIZE_P-1:0];
                wr_pred_data <= head_data[0];
            end
        end
    end

endmodule
